// File: rtl/layer_2_seq_mac.sv
// layer_2_seq_mac
//   Layer-2 evaluator built around one shared signed multiply-accumulate unit.
//   Each output j is bias[j] + sum_i hidden[i]*weight[j][i]. The sum takes N MAC
//   cycles plus one STORE cycle. All M results are published together, and done
//   pulses for one cycle when they are.
//
//   Optional feature (compile-time macro): LAYER2_SEQ_RELU_EN
//     defined     -> a negative accumulator is stored as 0 (ReLU output)
//     not defined -> the accumulator is stored unmodified (signed linear output)
//
// Ports
//   clk                  clock, rising edge
//   rst                  synchronous active-high reset
//   start                begin an evaluation; sampled only while idle
//   hidden_input_vector  N x hidden_neuron_size; hidden i at [i*HS +: HS]
//   weight_vector        M x N x weight_size; weight (j,i) at [(j*N+i)*WS +: WS]
//   bias_vector          M x bias_size; bias j at [j*BS +: BS]
//   busy                 high whenever not idle
//   done                 one-cycle pulse when results are published
//   valid                activation_vector holds the last completed evaluation
//   activation_vector    M x activation_size; result j at [j*AS +: AS]
module layer_2_seq_mac #(
   parameter int weight_size              = 5,
   parameter int bias_size                = 6,
   parameter int number_of_hidden_neurons = 5,
   parameter int number_of_outputs        = 2,
   parameter int hidden_neuron_size       = 54,
   parameter int activation_size          = 131
) (
   input  logic                                                      clk,
   input  logic                                                      rst,
   input  logic                                                      start,
   input  logic [number_of_hidden_neurons*hidden_neuron_size-1:0]    hidden_input_vector,
   input  logic [number_of_outputs*number_of_hidden_neurons*weight_size-1:0] weight_vector,
   input  logic [number_of_outputs*bias_size-1:0]                    bias_vector,
   output logic                                                      busy,
   output logic                                                      done,
   output logic                                                      valid,
   output logic [number_of_outputs*activation_size-1:0]              activation_vector
);
   localparam int N  = number_of_hidden_neurons;
   localparam int M  = number_of_outputs;
   localparam int HS = hidden_neuron_size;
   localparam int WS = weight_size;
   localparam int BS = bias_size;
   localparam int AS = activation_size;
   localparam int PW = HS + WS;                  // exact signed product width
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int JW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

   state_t                       state_q;
   logic [N-1:0][HS-1:0]         hid_q;
   logic [M-1:0][N-1:0][WS-1:0]  wgt_q;          // [j][i] matches (j*N+i) packing
   logic [M-1:0][BS-1:0]         bias_q;
   logic [M-1:0][AS-1:0]         res_q;          // staging buffer, published in DONE
   logic [M-1:0][AS-1:0]         act_q;
   logic [AS-1:0]                acc_q, acc_d, store_d;
   logic [IW-1:0]                i_q;
   logic [JW-1:0]                j_q;
   logic                         busy_q, done_q, valid_q;

   logic [HS-1:0]                hid_sel;
   logic [WS-1:0]                wgt_sel;
   logic signed [PW-1:0]         h_ext, w_ext, prod;

   function automatic logic [AS-1:0] sext_bias(input logic [BS-1:0] b);
      return {{(AS-BS){b[BS-1]}}, b};
   endfunction

   // Operands are sign-extended to the product width up front, so the
   // truncated PW-bit product is exact.
   always_comb begin
      hid_sel = hid_q[i_q];
      wgt_sel = wgt_q[j_q][i_q];
      h_ext   = {{WS{hid_sel[HS-1]}}, hid_sel};
      w_ext   = {{HS{wgt_sel[WS-1]}}, wgt_sel};
      prod    = h_ext * w_ext;
      acc_d   = acc_q + {{(AS-PW){prod[PW-1]}}, prod};
`ifdef LAYER2_SEQ_RELU_EN
      store_d = acc_q[AS-1] ? '0 : acc_q;
`else
      store_d = acc_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hid_q   <= '0;
         wgt_q   <= '0;
         bias_q  <= '0;
         res_q   <= '0;
         act_q   <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  hid_q   <= hidden_input_vector;
                  wgt_q   <= weight_vector;
                  bias_q  <= bias_vector;
                  acc_q   <= sext_bias(bias_vector[BS-1:0]);
                  i_q     <= '0;
                  j_q     <= '0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_MAC;
               end
            end
            S_MAC: begin
               acc_q <= acc_d;
               if (i_q == IW'(N-1)) state_q <= S_STORE;
               else                 i_q     <= i_q + 1'b1;
            end
            S_STORE: begin
               res_q[j_q] <= store_d;
               if (j_q == JW'(M-1)) begin
                  state_q <= S_DONE;
               end else begin
                  j_q     <= j_q + 1'b1;
                  i_q     <= '0;
                  acc_q   <= sext_bias(bias_q[j_q + 1'b1]);
                  state_q <= S_MAC;
               end
            end
            S_DONE: begin
               // All slices update on the same edge.
               act_q   <= res_q;
               valid_q <= 1'b1;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign valid             = valid_q;
   assign activation_vector = act_q;

endmodule

// File: tb/tb_layer_2_seq_mac.sv
module tb_layer_2_seq_mac;
   localparam int N = 5, M = 2, HS = 54, WS = 5, BS = 6, AS = 131;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [N*HS-1:0]     hid;
   logic [M*N*WS-1:0]   wv;
   logic [M*BS-1:0]     bv;
   logic                busy, done, valid;
   logic [M*AS-1:0]     act;

   layer_2_seq_mac dut (
      .clk(clk), .rst(rst), .start(start),
      .hidden_input_vector(hid), .weight_vector(wv), .bias_vector(bv),
      .busy(busy), .done(done), .valid(valid), .activation_vector(act)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic signed [AS-1:0] e0;
      logic signed [AS-1:0] e1;
   } exp_t;
   exp_t sb[$];

   int total = 0, passed = 0;

   task automatic chk(input string nm, input logic [AS-1:0] got, input logic [AS-1:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      else passed++;
   endtask

   function automatic logic signed [AS-1:0] relu(input logic signed [AS-1:0] x);
`ifdef LAYER2_SEQ_RELU_EN
      return (x < 0) ? '0 : x;
`else
      return x;
`endif
   endfunction

   // Monitor: every done pulse is matched against the oldest expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("slice0", act[0*AS +: AS], e.e0);
            chk("slice1", act[1*AS +: AS], e.e1);
            chk("valid_at_done", valid, 1'b1);
            chk("busy_at_done", busy, 1'b0);
         end
      end
   end

   task automatic set_uniform(input logic [HS-1:0] h, input logic [WS-1:0] w,
                              input logic [BS-1:0] b0, input logic [BS-1:0] b1);
      for (int i = 0; i < N; i++) hid[i*HS +: HS] = h;
      for (int k = 0; k < M*N; k++) wv[k*WS +: WS] = w;
      bv = {b1, b0};
   endtask

   task automatic wait_done(output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) begin
            at = cyc;
            return;
         end
      end
      chk("done_timeout", 1'b0, 1'b1);
   endtask

   // Inputs must already be set; pulses start for one edge and checks latency.
   task automatic run_eval(input logic signed [AS-1:0] x0, input logic signed [AS-1:0] x1);
      int e0, t;
      exp_t e;
      e.e0 = relu(x0);
      e.e1 = relu(x1);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0 = cyc;
      chk("busy_after_start", busy, 1'b1);
      chk("valid_cleared", valid, 1'b0);
      wait_done(t);
      chk("latency", AS'(t - e0), AS'(13));
   endtask

   initial begin
      int e0, t1, t2;
      exp_t e;
      rst = 1'b1;
      start = 1'b0;
      set_uniform('0, '0, '0, '0);
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_act", act[AS-1:0] | act[2*AS-1:AS], '0);
      rst = 1'b0;

      // All ones: 5*1 + 0
      set_uniform(54'd1, 5'd1, 6'd0, 6'd0);
      run_eval(131'sd5, 131'sd5);

      // hidden -3, weights 2: 5*(-6) = -30, biases -1 / +7
      set_uniform(-54'sd3, 5'sd2, -6'sd1, 6'sd7);
      run_eval(-131'sd31, -131'sd23);

      // Extremes: (-2^53)*(-16) = 2^57 per term
      set_uniform({1'b1, 53'b0}, -5'sd16, -6'sd32, -6'sd32);
      run_eval((131'sd5 <<< 57) - 131'sd32, (131'sd5 <<< 57) - 131'sd32);

      // start held high; inputs changed after edge 3 affect only the second run
      @(negedge clk);
      set_uniform(54'd1, 5'd1, 6'd0, 6'd0);
      e.e0 = relu(131'sd5);
      e.e1 = relu(131'sd5);
      sb.push_back(e);
      start = 1'b1;
      @(negedge clk);
      e0 = cyc;
      repeat (3) @(negedge clk);
      set_uniform(-54'sd3, 5'sd2, -6'sd1, 6'sd7);
      wait_done(t1);
      chk("held_latency", AS'(t1 - e0), AS'(13));
      e.e0 = relu(-131'sd31);
      e.e1 = relu(-131'sd23);
      sb.push_back(e);
      wait_done(t2);
      start = 1'b0;
      chk("done_spacing", AS'(t2 - t1), AS'(14));

      // Reset mid-run at edge 6: abort, no done
      set_uniform(54'd1, 5'd1, 6'd0, 6'd0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_valid", valid, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_act", act[AS-1:0] | act[2*AS-1:AS], '0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Distinct weights (j,i) = i+1-3j, hidden i = i, bias 0:
      // j=0: 0*1+1*2+2*3+3*4+4*5 = 40 ; j=1: 0*-2+1*-1+2*0+3*1+4*2 = 10
      for (int i = 0; i < N; i++) hid[i*HS +: HS] = HS'(i);
      for (int j = 0; j < M; j++)
         for (int i = 0; i < N; i++) wv[(j*N+i)*WS +: WS] = WS'(i + 1 - 3*j);
      bv = '0;
      run_eval(131'sd40, 131'sd10);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", AS'(sb.size()), '0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
